// File: rtl/sample_collector_pkg.sv
// Shared constants for the sampler / collector pair: sample width, reload
// schedule and the phase counter width both ends must agree on.
package sample_collector_pkg;

   localparam int SAMPLE_W_DEF = 4;
   localparam int PERIOD_DEF   = 12;
   localparam int PACK_DEF     = 4;
   localparam int DEPTH_DEF    = 4;
   localparam int PHASE_W      = $clog2(PERIOD_DEF + 1);

   typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/sample_collector_sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers; head data is presented
// combinationally and reads as zero while empty.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   // A push into a full FIFO is only taken when a pop frees the head slot in the same cycle.
   always_comb begin
      level   = wr_q - rd_q;
      empty   = (wr_q == rd_q);
      full    = (level == DEPTH_C);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      if (push_ok) begin
         wr_d = wr_q + (AW+1)'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_ok) begin
         rd_d = rd_q + (AW+1)'(1);
      end else begin
         rd_d = rd_q;
      end
      if (empty) begin
         dout = '0;
      end else begin
         dout = mem_q[rd_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/sample_collector.sv
// Receive side of the periodic sample stream: follows the sampler's reload
// schedule, packs PACK samples per word and queues words for the consumer.
module sample_collector
   import sample_collector_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int PERIOD   = PERIOD_DEF,
   parameter int PACK     = PACK_DEF,
   parameter int DEPTH    = DEPTH_DEF
) (
   input  logic                       clk_in,
   input  logic                       rst,
   input  logic                       sync,
   input  logic [SAMPLE_W-1:0]        sample_in,
   input  logic                       clear,
   output logic [SAMPLE_W*PACK-1:0]   word_out,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int WORD_W = SAMPLE_W * PACK;
   localparam int PW     = $clog2(PERIOD + 1);
   localparam int SW     = $clog2(PACK);
   localparam logic [PW-1:0] PHASE_RELOAD = PW'(PERIOD);
   localparam logic [SW-1:0] SLOT_LAST    = SW'(PACK - 1);

   logic [PW-1:0]     phase_q, phase_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [WORD_W-1:0] pack_q, pack_d;
   logic              overflow_q, overflow_d;
   logic [WORD_W-1:0] word_in;
   logic              capture;
   logic              push;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;

   // Phase counter mirrors the sampler; capture lands one edge after its reload.
   always_comb begin
      capture = 1'b0;
      phase_d = phase_q;
      if (sync) begin
         phase_d = '0;
      end else begin
         capture = (phase_q == PHASE_RELOAD);
         if (phase_q == '0) begin
            phase_d = PHASE_RELOAD;
         end else begin
            phase_d = phase_q - PW'(1);
         end
      end
   end

   // The last sample bypasses the pack register so the word is pushed on its capture edge.
   always_comb begin
      pack_d  = pack_q;
      slot_d  = slot_q;
      word_in = pack_q;
      word_in[(PACK-1)*SAMPLE_W +: SAMPLE_W] = sample_in;
      push    = capture && (slot_q == SLOT_LAST);
      if (capture) begin
         pack_d[int'(slot_q)*SAMPLE_W +: SAMPLE_W] = sample_in;
         slot_d = slot_q + SW'(1);
      end else begin
         slot_d = slot_q;
      end
   end

   // A drop sets the sticky flag even when clear is asserted in the same cycle.
   always_comb begin
      word_valid = !fifo_empty;
      pop        = word_valid && word_ready;
      drop       = push && fifo_full && !pop;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clear) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      overflow = overflow_q;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         phase_q    <= '0;
         slot_q     <= '0;
         pack_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         slot_q     <= slot_d;
         pack_q     <= pack_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (word_in),
      .dout  (word_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

endmodule
